// File: rtl/wb3_master.sv
// Single-outstanding command-to-Wishbone B3 classic master with interrupt edge pulse.
// Optional bus timeout is enabled by defining WB3_MASTER_TIMEOUT_EN.
module wb3_master #(
  parameter int unsigned ADDR_WIDTH     = 3,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic                  wb_we_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_inta_i,
  output logic                  irq_pulse
);

  localparam int unsigned CNT_WIDTH = 16;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t state, state_next;
  logic   tmo_hit;
  logic   inta_q;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("TIMEOUT_CYCLES out of range 2..65535");
  end

`ifdef WB3_MASTER_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] tmo_cnt;

  // Expiry is the last permitted strobe cycle passing with no ack.
  assign tmo_hit = (tmo_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == IDLE && req_valid) begin
      tmo_cnt <= '0;
    end else if (state == BUS && !wb_ack_i) begin
      tmo_cnt <= tmo_cnt + CNT_WIDTH'(1);
    end
  end

  // Ack takes priority over a simultaneous expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err <= 1'b0;
    end else if (state == BUS && wb_ack_i) begin
      rsp_err <= 1'b0;
    end else if (state == BUS && tmo_hit) begin
      rsp_err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    wb_cyc_o   = 1'b0;
    wb_stb_o   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = BUS;
      end
      BUS: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        if (wb_ack_i || tmo_hit) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command capture; bus fields hold their values outside BUS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we_o   <= 1'b0;
      wb_addr_o <= '0;
      wb_dat_o  <= '0;
    end else if (state == IDLE && req_valid) begin
      wb_we_o   <= req_we;
      wb_addr_o <= req_addr;
      wb_dat_o  <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= '0;
    end else if (state == BUS && wb_ack_i) begin
      rsp_rdata <= wb_we_o ? '0 : wb_dat_i;
    end else if (state == BUS && tmo_hit) begin
      rsp_rdata <= '0;
    end
  end

  // Interrupt rising-edge detector, free-running alongside the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inta_q    <= 1'b0;
      irq_pulse <= 1'b0;
    end else begin
      inta_q    <= wb_inta_i;
      irq_pulse <= wb_inta_i & ~inta_q;
    end
  end

endmodule

// File: tb/tb_wb3_master.sv
// Randomized scoreboard bench for wb3_master with a behavioural Wishbone slave.
// Timeout scenarios are exercised when WB3_MASTER_TIMEOUT_EN is defined.
module tb_wb3_master;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 8;
`ifdef WB3_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic          wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_inta_i, irq_pulse;

  wb3_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i),
    .wb_inta_i(wb_inta_i), .irq_pulse(irq_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {logic err; logic [DW-1:0] rdata;} rsp_t;
  typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] dat; int len;} bus_t;

  rsp_t          rsp_q[$];
  bus_t          bus_q[$];
  int            delay_q[$];
  logic [DW-1:0] ref_mem  [2**AW];
  logic [DW-1:0] slave_mem[2**AW];
  int            hold_cycles = 0;
  int            irq_high = 0;
  int            irq_events = 0;

  // Slave: acks after the queued number of wait states, random ack noise when idle.
  initial begin
    int cnt = 0;
    int d = 0;
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(negedge clk);
      if (wb_cyc_o && wb_stb_o) begin
        if (cnt == 0) d = (delay_q.size() != 0) ? delay_q.pop_front() : 0;
        if (cnt == d) begin
          wb_ack_i = 1'b1;
          if (wb_we_o) begin
            slave_mem[wb_addr_o] = wb_dat_o;
            wb_dat_i = DW'($urandom);
          end else begin
            wb_dat_i = slave_mem[wb_addr_o];
          end
        end else begin
          wb_ack_i = 1'b0;
          wb_dat_i = DW'($urandom);
        end
        cnt++;
      end else begin
        cnt = 0;
        wb_ack_i = 1'($urandom);
        wb_dat_i = DW'($urandom);
      end
    end
  end

  // Bus monitor: fields stable for the whole strobe, strobe length as predicted.
  initial begin
    bus_t e;
    int   len = 0;
    bit   active = 1'b0;
    e = '{1'b0, '0, '0, 0};
    forever begin
      @(negedge clk);
      if (wb_stb_o) begin
        if (!active) begin
          active = 1'b1;
          len = 0;
          if (bus_q.size() == 0) check("bus_unexpected", 1, 0);
          else e = bus_q.pop_front();
        end
        len++;
        check("bus_cyc", 32'(wb_cyc_o), 1);
        check("bus_we", 32'(wb_we_o), 32'(e.we));
        check("bus_addr", 32'(wb_addr_o), 32'(e.addr));
        check("bus_dat", 32'(wb_dat_o), 32'(e.dat));
      end else if (active) begin
        active = 1'b0;
        check("stb_len", 32'(len), 32'(e.len));
      end
    end
  end

  // Response monitor: drives rsp_ready, checks holding and payload.
  initial begin
    logic          pv = 1'b0, pr = 1'b0, pe = 1'b0;
    logic [DW-1:0] pd = '0;
    rsp_t          e;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (pv && !pr) begin
        check("rsp_hold_valid", 32'(rsp_valid), 1);
        check("rsp_hold_rdata", 32'(rsp_rdata), 32'(pd));
        check("rsp_hold_err", 32'(rsp_err), 32'(pe));
      end
      if (rsp_valid && hold_cycles > 0) begin
        rsp_ready = 1'b0;
        hold_cycles--;
      end else begin
        rsp_ready = ($urandom % 4) != 0;
      end
      if (rsp_valid) begin
        check("req_ready_in_resp", 32'(req_ready), 0);
        if (rsp_ready) begin
          if (rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
          else begin
            e = rsp_q.pop_front();
            check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
            check("rsp_err", 32'(rsp_err), 32'(e.err));
          end
        end
      end
      pv = rsp_valid; pr = rsp_ready; pd = rsp_rdata; pe = rsp_err;
    end
  end

  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (irq_pulse) irq_high++;
      if (irq_pulse && !prev) irq_events++;
      prev = irq_pulse;
    end
  end

  // Issue one command; expectations come from the reference memory and delay rules.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input int d, input bit abort);
    bit tmo;
    int len;
    int n = 0;
    tmo = TO_EN && (d + 1 > int'(TO));
    len = abort ? 3 : (tmo ? int'(TO) : d + 1);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    delay_q.push_back(d);
    bus_q.push_back('{we, addr, wdata, len});
    if (!abort) begin
      if (tmo) rsp_q.push_back('{1'b1, '0});
      else if (we) rsp_q.push_back('{1'b0, '0});
      else rsp_q.push_back('{1'b0, ref_mem[addr]});
      if (!tmo && we) ref_mem[addr] = wdata;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = AW'($urandom); req_wdata = DW'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0 || !req_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("drain_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; wb_inta_i = 1'b0;
    for (int i = 0; i < 2**AW; i++) begin
      ref_mem[i] = DW'($urandom);
      slave_mem[i] = ref_mem[i];
    end
    ref_mem[4] = 8'h3C;
    slave_mem[4] = 8'h3C;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_cyc", 32'(wb_cyc_o), 0);
    check("rst_stb", 32'(wb_stb_o), 0);
    check("rst_we", 32'(wb_we_o), 0);
    check("rst_addr", 32'(wb_addr_o), 0);
    check("rst_dat", 32'(wb_dat_o), 0);
    check("rst_rdata", 32'(rsp_rdata), 0);
    check("rst_err", 32'(rsp_err), 0);
    check("rst_irq", 32'(irq_pulse), 0);
    rst = 1'b0;

    issue(1'b1, 3'd3, 8'hA5, 0, 1'b0);
    wait_drain();
    hold_cycles = 4;
    issue(1'b0, 3'd4, 8'h00, 5, 1'b0);
    wait_drain();
    check("req_ready_after_hold", 32'(req_ready), 1);
    if (TO_EN) begin
      issue(1'b0, 3'd1, 8'h00, int'(TO) - 1, 1'b0);
      issue(1'b1, 3'd2, 8'h5A, int'(TO), 1'b0);
      issue(1'b0, 3'd5, 8'h00, int'(TO) + 4, 1'b0);
    end

    for (int i = 0; i < 60; i++) begin
      int d;
      d = TO_EN ? int'($urandom % 11) : int'($urandom % 7);
      issue(1'($urandom), AW'($urandom), DW'($urandom), d, 1'b0);
      repeat ($urandom % 3) @(negedge clk);
    end
    wait_drain();

    issue(1'b0, 3'd2, 8'h00, 20, 1'b1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_cyc", 32'(wb_cyc_o), 0);
    check("mid_rst_stb", 32'(wb_stb_o), 0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    check("mid_rst_req_ready", 32'(req_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 1);
    check("post_rst_rsp_valid", 32'(rsp_valid), 0);

    irq_high = 0;
    irq_events = 0;
    wb_inta_i = 1'b1;
    repeat (10) @(negedge clk);
    wb_inta_i = 1'b0;
    repeat (3) @(negedge clk);
    wb_inta_i = 1'b1;
    repeat (4) @(negedge clk);
    wb_inta_i = 1'b0;
    repeat (3) @(negedge clk);
    check("irq_events", 32'(irq_events), 2);
    check("irq_high_cycles", 32'(irq_high), 2);

    check("rsp_q_empty", 32'(rsp_q.size()), 0);
    check("bus_q_empty", 32'(bus_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/wb3_master.md
WB3_MASTER -- requirements
Module: wb3_master

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 3, Wishbone address width; DATA_WIDTH, 8, Wishbone data width; TIMEOUT_CYCLES, 256, maximum strobe cycles without ack (valid range 2..65535).
REQ-002 Clock and reset SHALL be: one clock, clk; reset rst, asynchronous and active-high.
REQ-003 Ports SHALL be, clock and reset first:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when high with req_valid
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  register address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
- rsp_err  out  1  transaction timed out
- wb_addr_o  out  ADDR_WIDTH  Wishbone address
- wb_dat_o  out  DATA_WIDTH  Wishbone write data
- wb_dat_i  in  DATA_WIDTH  Wishbone read data
- wb_we_o  out  1  Wishbone write enable
- wb_stb_o  out  1  Wishbone strobe
- wb_cyc_o  out  1  Wishbone cycle
- wb_ack_i  in  1  Wishbone acknowledge
- wb_inta_i  in  1  slave interrupt, level
- irq_pulse  out  1  one-cycle pulse on wb_inta_i rising edge

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, BUS and RESP.
REQ-005 req_ready SHALL be high only in IDLE; the handshake (req_valid and req_ready) SHALL latch req_we/req_addr/req_wdata into wb_we_o/wb_addr_o/wb_dat_o and move to BUS.
REQ-006 In BUS, wb_cyc_o and wb_stb_o SHALL both be 1, with addr/dat/we stable; in IDLE and RESP both SHALL be 0.
REQ-007 wb_cyc_o/wb_stb_o SHALL rise on the clock edge after the request handshake (1-cycle latency).
REQ-008 wb_ack_i sampled high in BUS SHALL cause a move to RESP, capture wb_dat_i into rsp_rdata for reads (0 for writes), and set rsp_err=0.
REQ-009 rsp_valid SHALL be high exactly in RESP; rsp_rdata/rsp_err SHALL remain stable until rsp_valid and rsp_ready are both high, then the FSM returns to IDLE.
REQ-010 A complete zero-wait transaction SHALL take 3 cycles: handshake, BUS, RESP with rsp_ready=1.
REQ-011 wb_ack_i in IDLE or RESP SHALL be ignored.
REQ-012 wb_addr_o, wb_dat_o and wb_we_o SHALL hold their last values outside BUS.
REQ-013 irq_pulse SHALL be 1 for one cycle after wb_inta_i goes 0->1, based on a registered previous value; it is independent of the FSM.

Reset
REQ-014 On rst high, state SHALL be IDLE immediately, with all outputs 0 except req_ready=1; the timeout counter and the inta history register SHALL be 0.
REQ-015 A reset during BUS SHALL drop wb_cyc_o/wb_stb_o asynchronously, and the pending command SHALL be discarded with no response.

Configuration
REQ-016 With the macro WB3_MASTER_TIMEOUT_EN defined, a 16-bit counter SHALL clear on BUS entry and increment every BUS cycle without ack.
- If TIMEOUT_CYCLES consecutive BUS cycles pass without ack, the FSM SHALL move to RESP with rsp_err=1 and rsp_rdata=0.
- If ack arrives on the same edge as expiry, ack SHALL win (rsp_err=0).
REQ-017 Without WB3_MASTER_TIMEOUT_EN, no counter SHALL exist, BUS SHALL wait indefinitely for ack, and rsp_err SHALL be tied to 0.

Verification
REQ-018 Write addr=3 wdata=0xA5, ack on first BUS cycle -> wb_we_o=1, wb_addr_o=3, wb_dat_o=0xA5 for 1 cycle; rsp_valid next cycle with rsp_err=0, rsp_rdata=0.
REQ-019 Read addr=4, ack after 5 wait cycles with wb_dat_i=0x3C -> wb_stb_o high for 6 cycles; rsp_rdata=0x3C.
REQ-020 Read completes with rsp_ready held 0 for 4 cycles -> rsp_valid/rsp_rdata stable for 4 cycles, req_ready=0 throughout, IDLE after acceptance.
REQ-021 With WB3_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack -> stb high for exactly 8 cycles, then rsp_err=1 and rsp_rdata=0; a second case with ack on cycle 8 -> rsp_err=0.
REQ-022 rst asserted mid-BUS -> wb_cyc_o=wb_stb_o=0 at once, no rsp_valid, req_ready=1 after release.
REQ-023 wb_inta_i held high 10 cycles, then low, then high again -> exactly two single-cycle irq_pulse events.
